// File: rtl/operand_issue.sv
// Decode / operand-fetch stage with the ID/EX pipeline register feeding the ALU.
// Holds the register file, forwards from EX/MEM/WB, stalls on load-use and bubbles on flush.
module operand_issue #(
  parameter logic [31:0] NOP_INS = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_valid,
  input  logic [31:0] if_ins,
  input  logic [31:0] if_pc,
  output logic        if_ready,
  input  logic        flush,
  input  logic [31:0] ex_result,
  input  logic        mem_fwd_en,
  input  logic [4:0]  mem_fwd_addr,
  input  logic [31:0] mem_fwd_data,
  input  logic        wb_en,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic [31:0] alu_op1,
  output logic [31:0] alu_op2,
  output logic [31:0] alu_ins,
  output logic [31:0] alu_pc,
  output logic        ex_valid,
  output logic [4:0]  ex_dst,
  output logic        ex_is_load,
  output logic [31:0] ex_store_data
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  logic [31:0] rf_q [32];

  logic [31:0] op1_q, op1_d;
  logic [31:0] op2_q, op2_d;
  logic [31:0] ins_q, ins_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [4:0]  dst_q, dst_d;
  logic        is_load_q, is_load_d;
  logic [31:0] store_q, store_d;

  logic [5:0]  opcode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [5:0]  funct;
  logic [31:0] imm_sext;
  logic [31:0] imm_zext;
  logic        is_nop;

  assign opcode   = if_ins[31:26];
  assign rs       = if_ins[25:21];
  assign rt       = if_ins[20:16];
  assign rd       = if_ins[15:11];
  assign funct    = if_ins[5:0];
  assign imm_sext = {{16{if_ins[15]}}, if_ins[15:0]};
  assign imm_zext = {16'h0000, if_ins[15:0]};
  assign is_nop   = (if_ins == 32'h0000_0000);

  // Youngest producer wins; a load in EX has no value yet, so it is skipped here
  // and covered by the load-use stall instead.
  function automatic logic [31:0] operand_val(
    input logic [4:0]  r,
    input logic [31:0] rf_val,
    input logic        ex_v,
    input logic        ex_ld,
    input logic [4:0]  ex_d,
    input logic [31:0] ex_res,
    input logic        m_en,
    input logic [4:0]  m_addr,
    input logic [31:0] m_data,
    input logic        w_en,
    input logic [4:0]  w_addr,
    input logic [31:0] w_data
  );
    logic [31:0] v;
    if (r == 5'd0)                          v = 32'h0;
    else if (ex_v && !ex_ld && ex_d == r)   v = ex_res;
    else if (m_en && m_addr == r)           v = m_data;
    else if (w_en && w_addr == r)           v = w_data;
    else                                    v = rf_val;
    return v;
  endfunction

  logic [31:0] rs_val;
  logic [31:0] rt_val;

  assign rs_val = operand_val(rs, rf_q[rs], valid_q, is_load_q, dst_q, ex_result,
                              mem_fwd_en, mem_fwd_addr, mem_fwd_data,
                              wb_en, wb_addr, wb_data);
  assign rt_val = operand_val(rt, rf_q[rt], valid_q, is_load_q, dst_q, ex_result,
                              mem_fwd_en, mem_fwd_addr, mem_fwd_data,
                              wb_en, wb_addr, wb_data);

  logic [31:0] dec_op1;
  logic [31:0] dec_op2;
  logic [4:0]  dec_dst;
  logic        dec_load;
  logic [31:0] dec_store;
  logic        uses_rs;
  logic        uses_rt;

  always_comb begin
    dec_op1   = 32'h0;
    dec_op2   = 32'h0;
    dec_dst   = 5'd0;
    dec_load  = 1'b0;
    dec_store = 32'h0;
    uses_rs   = 1'b1;
    uses_rt   = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        dec_op1 = rs_val;
        dec_op2 = rt_val;
        uses_rt = 1'b1;
        dec_dst = (is_nop || funct == FN_JR) ? 5'd0 : rd;
        if (is_nop) uses_rs = 1'b0;
      end
      OP_ANDI, OP_ORI, OP_LUI: begin
        dec_op1 = rs_val;
        dec_op2 = imm_zext;
        dec_dst = rt;
        if (opcode == OP_LUI) uses_rs = 1'b0;
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_LW: begin
        dec_op1  = rs_val;
        dec_op2  = imm_sext;
        dec_dst  = rt;
        dec_load = (opcode == OP_LW);
      end
      OP_SW: begin
        dec_op1   = rs_val;
        dec_op2   = imm_sext;
        dec_store = rt_val;
        uses_rt   = 1'b1;
      end
      OP_JAL: begin
        dec_dst = 5'd31;
        uses_rs = 1'b0;
      end
      default: begin
        dec_op1 = 32'h0;
      end
    endcase
  end

  logic stall;

  assign stall = if_valid && valid_q && is_load_q && (dst_q != 5'd0) &&
                 ((uses_rs && rs == dst_q) || (uses_rt && rt == dst_q));

  // Flush outranks the stall: the held instruction is dropped, so it is consumed.
  assign if_ready = !(stall && !flush);

  always_comb begin
    op1_d     = 32'h0;
    op2_d     = 32'h0;
    ins_d     = NOP_INS;
    pc_d      = 32'h0;
    valid_d   = 1'b0;
    dst_d     = 5'd0;
    is_load_d = 1'b0;
    store_d   = 32'h0;
    if (if_valid && !flush && !stall) begin
      op1_d     = dec_op1;
      op2_d     = dec_op2;
      ins_d     = if_ins;
      pc_d      = if_pc;
      valid_d   = 1'b1;
      dst_d     = dec_dst;
      is_load_d = dec_load;
      store_d   = dec_store;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op1_q     <= 32'h0;
      op2_q     <= 32'h0;
      ins_q     <= NOP_INS;
      pc_q      <= 32'h0;
      valid_q   <= 1'b0;
      dst_q     <= 5'd0;
      is_load_q <= 1'b0;
      store_q   <= 32'h0;
    end else begin
      op1_q     <= op1_d;
      op2_q     <= op2_d;
      ins_q     <= ins_d;
      pc_q      <= pc_d;
      valid_q   <= valid_d;
      dst_q     <= dst_d;
      is_load_q <= is_load_d;
      store_q   <= store_d;
    end
  end

  // r0 is never written, so its storage stays at the reset value of zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= 32'h0;
    end else if (wb_en && wb_addr != 5'd0) begin
      rf_q[wb_addr] <= wb_data;
    end
  end

  assign alu_op1       = op1_q;
  assign alu_op2       = op2_q;
  assign alu_ins       = ins_q;
  assign alu_pc        = pc_q;
  assign ex_valid      = valid_q;
  assign ex_dst        = dst_q;
  assign ex_is_load    = is_load_q;
  assign ex_store_data = store_q;

endmodule

// File: tb/tb_operand_issue.sv
// Directed bench for operand_issue: the driver pushes the expected ID/EX contents
// per cycle, a monitor pops and compares them after each rising edge.
module tb_operand_issue;

  typedef struct packed {
    logic        valid;
    logic [4:0]  dst;
    logic        is_load;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] ins;
    logic [31:0] pc;
    logic [31:0] store;
  } exp_t;

  localparam int W = $bits(exp_t);

  logic        clk;
  logic        rst_n;
  logic        if_valid;
  logic [31:0] if_ins;
  logic [31:0] if_pc;
  logic        if_ready;
  logic        flush;
  logic [31:0] ex_result;
  logic        mem_fwd_en;
  logic [4:0]  mem_fwd_addr;
  logic [31:0] mem_fwd_data;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [31:0] alu_op1;
  logic [31:0] alu_op2;
  logic [31:0] alu_ins;
  logic [31:0] alu_pc;
  logic        ex_valid;
  logic [4:0]  ex_dst;
  logic        ex_is_load;
  logic [31:0] ex_store_data;

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  operand_issue #(.NOP_INS(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_valid(if_valid), .if_ins(if_ins), .if_pc(if_pc), .if_ready(if_ready),
    .flush(flush), .ex_result(ex_result),
    .mem_fwd_en(mem_fwd_en), .mem_fwd_addr(mem_fwd_addr), .mem_fwd_data(mem_fwd_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_ins(alu_ins), .alu_pc(alu_pc),
    .ex_valid(ex_valid), .ex_dst(ex_dst), .ex_is_load(ex_is_load),
    .ex_store_data(ex_store_data)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic v, input logic [4:0] d, input logic ld,
                              input logic [31:0] o1, input logic [31:0] o2,
                              input logic [31:0] ins, input logic [31:0] pc,
                              input logic [31:0] st);
    exp_t e;
    e = '{valid: v, dst: d, is_load: ld, op1: o1, op2: o2, ins: ins, pc: pc, store: st};
    return e;
  endfunction

  function automatic exp_t bubble();
    return mk(1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
  endfunction

  function automatic exp_t sample();
    return mk(ex_valid, ex_dst, ex_is_load, alu_op1, alu_op2, alu_ins, alu_pc, ex_store_data);
  endfunction

  task automatic idle_inputs();
    if_valid = 1'b0; if_ins = 32'h0; if_pc = 32'h0; flush = 1'b0;
    ex_result = 32'h0; mem_fwd_en = 1'b0; mem_fwd_addr = 5'd0; mem_fwd_data = 32'h0;
    wb_en = 1'b0; wb_addr = 5'd0; wb_data = 32'h0;
  endtask

  task automatic issue(input logic [31:0] ins, input logic [31:0] pc);
    if_valid = 1'b1; if_ins = ins; if_pc = pc;
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    wb_en = 1'b1; wb_addr = a; wb_data = d;
  endtask

  // ---------------- driver ----------------
  // Called at a falling edge with inputs already set; returns at the next falling edge.
  task automatic drive_cycle(input string name, input exp_t e, input logic rdy);
    #1;
    check({name, ".if_ready"}, W'(if_ready), W'(rdy));
    exp_q.push_back(e);
    @(negedge clk);
    idle_inputs();
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(posedge clk) begin
    #1;
    if (rst_n && exp_q.size() > 0) begin
      logic [W-1:0] exp_v;
      exp_v = exp_q.pop_front();
      check("idex", W'(sample()), exp_v);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_state", W'(sample()), W'(bubble()));
    check("reset.if_ready", W'(if_ready), W'(1'b1));
    rst_n = 1'b1;

    wb(5'd8, 32'd5);
    drive_cycle("wb_r8", bubble(), 1'b1);
    wb(5'd9, 32'd7);
    drive_cycle("wb_r9", bubble(), 1'b1);

    issue(32'h0109_5020, 32'h100); wb(5'd1, 32'h20);
    drive_cycle("add_r10", mk(1, 5'd10, 0, 32'd5, 32'd7, 32'h0109_5020, 32'h100, 0), 1'b1);

    issue(32'h2001_FFFF, 32'h104); wb(5'd2, 32'h30);
    drive_cycle("addi_sext", mk(1, 5'd1, 0, 0, 32'hFFFF_FFFF, 32'h2001_FFFF, 32'h104, 0), 1'b1);

    issue(32'h3401_FFFF, 32'h108);
    drive_cycle("ori_zext", mk(1, 5'd1, 0, 0, 32'h0000_FFFF, 32'h3401_FFFF, 32'h108, 0), 1'b1);

    issue(32'h0022_1820, 32'h10C); ex_result = 32'h0000_FFFF;
    drive_cycle("add_r3_exfwd", mk(1, 5'd3, 0, 32'hFFFF, 32'h30, 32'h0022_1820, 32'h10C, 0), 1'b1);

    issue(32'h0061_2022, 32'h110); ex_result = 32'h11;
    mem_fwd_en = 1'b1; mem_fwd_addr = 5'd3; mem_fwd_data = 32'h77;
    drive_cycle("sub_ex_over_mem", mk(1, 5'd4, 0, 32'h11, 32'h20, 32'h0061_2022, 32'h110, 0), 1'b1);

    issue(32'h8CC5_0000, 32'h114);
    drive_cycle("lw_r5", mk(1, 5'd5, 1, 0, 0, 32'h8CC5_0000, 32'h114, 0), 1'b1);

    issue(32'h00A5_3820, 32'h118); ex_result = 32'hDEAD;
    drive_cycle("load_use_stall", bubble(), 1'b0);

    issue(32'h00A5_3820, 32'h118);
    mem_fwd_en = 1'b1; mem_fwd_addr = 5'd5; mem_fwd_data = 32'hABCD;
    drive_cycle("after_stall_memfwd",
                mk(1, 5'd7, 0, 32'hABCD, 32'hABCD, 32'h00A5_3820, 32'h118, 0), 1'b1);

    issue(32'h8CC5_0000, 32'h11C);
    drive_cycle("lw_r5_again", mk(1, 5'd5, 1, 0, 0, 32'h8CC5_0000, 32'h11C, 0), 1'b1);

    issue(32'h00A5_3820, 32'h120); flush = 1'b1;
    drive_cycle("stall_with_flush", bubble(), 1'b1);

    drive_cycle("no_duplicate", bubble(), 1'b1);

    issue(32'h0180_6820, 32'h124); wb(5'd12, 32'h99);
    drive_cycle("wb_same_cycle", mk(1, 5'd13, 0, 32'h99, 0, 32'h0180_6820, 32'h124, 0), 1'b1);

    issue(32'h0000_7020, 32'h128); wb(5'd0, 32'h55);
    drive_cycle("r0_wb_bypass", mk(1, 5'd14, 0, 0, 0, 32'h0000_7020, 32'h128, 0), 1'b1);

    issue(32'hAC0C_0008, 32'h12C);
    drive_cycle("sw_r0_read", mk(1, 5'd0, 0, 0, 32'h8, 32'hAC0C_0008, 32'h12C, 32'h99), 1'b1);

    issue(32'h0C00_0010, 32'h130);
    drive_cycle("jal", mk(1, 5'd31, 0, 0, 0, 32'h0C00_0010, 32'h130, 0), 1'b1);

    issue(32'h3C0A_1234, 32'h134);
    drive_cycle("lui", mk(1, 5'd10, 0, 0, 32'h1234, 32'h3C0A_1234, 32'h134, 0), 1'b1);

    issue(32'h03E0_0008, 32'h138); wb(5'd31, 32'h40);
    drive_cycle("jr", mk(1, 5'd0, 0, 32'h40, 0, 32'h03E0_0008, 32'h138, 0), 1'b1);

    issue(32'hFC00_0000, 32'h13C);
    drive_cycle("unknown_op", mk(1, 5'd0, 0, 0, 0, 32'hFC00_0000, 32'h13C, 0), 1'b1);

    issue(32'h0109_5020, 32'h140);
    drive_cycle("add_before_reset", mk(1, 5'd10, 0, 32'd5, 32'd7, 32'h0109_5020, 32'h140, 0), 1'b1);

    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", W'(sample()), W'(bubble()));
    @(negedge clk);
    rst_n = 1'b1;

    issue(32'h0109_5020, 32'h144);
    drive_cycle("rf_cleared", mk(1, 5'd10, 0, 0, 0, 32'h0109_5020, 32'h144, 0), 1'b1);

    @(negedge clk);
    check("queue_drained", W'(exp_q.size()), W'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/operand_issue.md
Name: operand_issue

Overview:
- Decode/operand-fetch stage and ID/EX pipeline register that drives the ALU's op1, op2, ins and pc inputs.
- Holds the 32x32 register file and decodes each fetched MIPS instruction into ALU operands plus a destination register.
- Forwards results from EX, MEM and WB, stalls one cycle on load-use hazards, and inserts bubbles on flush.
- Sits between instruction fetch and the combinational ALU.

Parameters:
- NOP_INS, 32'h00000000, instruction word used for a bubble (the ALU yields result 0 for it).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- if_valid  in  1  if_ins/if_pc hold a valid fetched instruction.
- if_ins  in  32  instruction word.
- if_pc  in  32  instruction address.
- if_ready  out  1  combinational; 1 = instruction consumed this cycle.
- flush  in  1  branch/jump redirect; discard the current ID instruction.
- ex_result  in  32  current ALU result for the instruction held in ID/EX.
- mem_fwd_en  in  1  MEM stage will write mem_fwd_addr.
- mem_fwd_addr  in  5  MEM destination register.
- mem_fwd_data  in  32  MEM result.
- wb_en  in  1  register file write enable.
- wb_addr  in  5  write address.
- wb_data  in  32  write data.
- alu_op1  out  32  registered operand 1.
- alu_op2  out  32  registered operand 2.
- alu_ins  out  32  registered instruction.
- alu_pc  out  32  registered pc.
- ex_valid  out  1  ID/EX holds a real instruction.
- ex_dst  out  5  destination register (0 = none).
- ex_is_load  out  1  ID/EX holds lw.
- ex_store_data  out  32  forwarded rt value for sw.

Behaviour:
- Reset (rst_n=0, asynchronous): all 32 registers cleared to 0. alu_op1, alu_op2 and alu_pc = 0, alu_ins = NOP_INS, ex_valid = 0, ex_dst = 0, ex_is_load = 0, ex_store_data = 0. Reset asserted mid-operation discards the in-flight instruction.
- Register file:
  - r0 always reads 0; writes to r0 are ignored.
  - Write occurs at the clock edge when wb_en=1.
- Operand value for a source register r (rs or rt), first match wins:
  - r==0 -> 0.
  - ex_valid && !ex_is_load && ex_dst==r -> ex_result.
  - mem_fwd_en && mem_fwd_addr==r -> mem_fwd_data.
  - wb_en && wb_addr==r -> wb_data.
  - otherwise register file contents.
- Decode by opcode ins[31:26]:
  - 000000 (R-type): op1=rs, op2=rt, dst=rd. jr: dst=0. nop (all-zero word): dst=0.
  - andi/ori/lui (001100/001101/001111): op1=rs, op2=zero-extended imm, dst=rt.
  - addi/addiu/slti/lw (001000/001001/001010/100011): op1=rs, op2=sign-extended imm, dst=rt. lw also sets ex_is_load.
  - sw (101011): op1=rs, op2=sign-extended imm, dst=0, ex_store_data=rt.
  - jal (000011): op1=op2=0, dst=31.
  - Any other opcode: op1=op2=0, dst=0; ins passed through unchanged.
- rt counts as a source only for R-type and sw. rs counts as a source for everything except jal, lui and the all-zero nop.
- Load-use stall:
  - Condition: if_valid && ex_valid && ex_is_load && ex_dst!=0 && ex_dst equals a used source register.
  - Effect: if_ready=0 and a bubble is loaded into ID/EX. Upstream must hold if_ins/if_pc. The next cycle re-evaluates with forwarding from MEM.
  - Latency: 1 cycle normally, 2 cycles on a load-use stall.
- flush: has priority over stall. Bubble is loaded, if_ready=1, if_ins discarded.
- if_valid=0: bubble is loaded, if_ready=1.
- Bubble contents: alu_ins=NOP_INS, op1=op2=pc=0, ex_valid=0, ex_dst=0, ex_is_load=0, ex_store_data=0.
- Otherwise ID/EX loads the decoded values each cycle, with ex_valid=1 and alu_pc=if_pc.

Test Plan:
- Reset, then wb writes r8=5 and r9=7; issue add r10,r8,r9 (0x01095020) -> next cycle alu_op1=5, alu_op2=7, ex_dst=10, ex_valid=1.
- Issue addi r1,r0,-1 (0x2001FFFF) -> alu_op2=0xFFFFFFFF. Issue ori r1,r0,0xFFFF -> alu_op2=0x0000FFFF. Both with ex_dst=1.
- Issue back-to-back add r3,r1,r2 then sub r4,r3,r1 with ex_result=0x11 -> second instruction's alu_op1=0x11 (EX forward beats a stale register file value).
- Issue lw r5,0(r6) then add r7,r5,r5 -> one cycle with if_ready=0 and ex_valid=0; next cycle alu_op1=alu_op2=mem_fwd_data (e.g. 0xABCD) when mem_fwd_addr=5.
- Load-use stall coincident with flush=1 -> if_ready=1, bubble loaded, no duplicate issue afterwards.
- Same-cycle wb write r12=0x99 and issue reading r12 -> alu_op1=0x99. wb write to r0 followed by a read of r0 -> 0. Assert rst_n=0 mid-stream -> outputs return to reset values immediately.
